// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package s2p_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/s2p_out_hold.sv
// Output word register with valid/ready handshake and sticky overrun detection.
module s2p_out_hold
  import s2p_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_rdy,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             ovf
);

  logic [WIDTH-1:0] dout_r;
  logic             dout_vld_r;
  logic             ovf_r;
  logic             room_s;
  logic             ovf_evt_s;

  // A slot is free when nothing is held or the held word leaves this edge.
  always_comb begin
    room_s    = 1'b0;
    ovf_evt_s = 1'b0;
    if (!dout_vld_r || dout_rdy) begin
      room_s = 1'b1;
    end else begin
      room_s = 1'b0;
    end
    if (load && !room_s) begin
      ovf_evt_s = 1'b1;
    end else begin
      ovf_evt_s = 1'b0;
    end
  end

  // Held word, valid flag and sticky overrun; a new overrun beats clr_err.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      dout_r     <= {WIDTH{1'b0}};
      dout_vld_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      if (load && room_s) begin
        dout_r     <= word;
        dout_vld_r <= 1'b1;
      end else if (dout_vld_r && dout_rdy) begin
        dout_vld_r <= 1'b0;
      end else begin
        dout_vld_r <= dout_vld_r;
      end
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (clr_err) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign ovf      = ovf_r;

endmodule

// File: rtl/serial2parallel.sv
// Deserializer: assembles strobed serial bits into WIDTH-bit words and hands
// them to a registered valid/ready output, flagging overrun and framing errors.
module serial2parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1,
  parameter int CONT      = 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             ovf,
  output logic             frm_err,
  input  logic             clr_err
);

  localparam int                CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] idx_s;
  logic [CNT_W-1:0] pos_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] word_s;
  logic             busy_r;
  logic             frm_err_r;
  logic             take_s;
  logic             restart_s;
  logic             frm_evt_s;
  logic             complete_s;

  // Decide whether this cycle's bit is captured, and whether it opens a new word.
  always_comb begin
    take_s    = 1'b0;
    restart_s = 1'b0;
    frm_evt_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Only reachable with CONT=0 or before the first word, so sof is required.
        if (sin_vld && sof) begin
          take_s    = 1'b1;
          restart_s = 1'b1;
        end else begin
          take_s    = 1'b0;
        end
      end
      SHIFT: begin
        if (sin_vld) begin
          take_s    = 1'b1;
          restart_s = sof;
          frm_evt_s = sof && (cnt_r != {CNT_W{1'b0}});
        end else begin
          take_s    = 1'b0;
        end
      end
      default: begin
        take_s    = 1'b0;
        restart_s = 1'b0;
        frm_evt_s = 1'b0;
      end
    endcase
  end

  // Place the bit, advance the counter and pick the next state.
  always_comb begin
    idx_s       = restart_s ? {CNT_W{1'b0}} : cnt_r;
    pos_s       = (LSB_FIRST != 0) ? idx_s : (LAST - idx_s);
    word_s      = restart_s ? {WIDTH{1'b0}} : shreg_r;
    word_s[pos_s] = sin;
    complete_s  = take_s && (idx_s == LAST);
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    if (take_s) begin
      cnt_nxt_s   = complete_s ? {CNT_W{1'b0}} : (idx_s + CNT_W'(1));
      state_nxt_s = (complete_s && (CONT == 0)) ? IDLE : SHIFT;
    end else begin
      cnt_nxt_s   = cnt_r;
      state_nxt_s = state_r;
    end
  end

  // FSM, counter, shift register, busy and sticky framing error.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      shreg_r   <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (cnt_nxt_s != {CNT_W{1'b0}});
      if (take_s) begin
        shreg_r <= word_s;
      end else begin
        shreg_r <= shreg_r;
      end
      if (frm_evt_s) begin
        frm_err_r <= 1'b1;
      end else if (clr_err) begin
        frm_err_r <= 1'b0;
      end else begin
        frm_err_r <= frm_err_r;
      end
    end
  end

  s2p_out_hold #(
    .WIDTH (WIDTH)
  ) u_out_hold (
    .clk      (clk),
    .rst_     (rst_),
    .load     (complete_s),
    .word     (word_s),
    .dout_rdy (dout_rdy),
    .clr_err  (clr_err),
    .dout     (dout),
    .dout_vld (dout_vld),
    .ovf      (ovf)
  );

  assign busy    = busy_r;
  assign frm_err = frm_err_r;

endmodule

// File: tb/tb_serial2parallel.sv
// Scoreboard bench: expected words are queued when sent and popped on handshake.
module tb_serial2parallel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_;
  logic       sin, sin_vld, sof, dout_rdy, clr_err;
  logic [3:0] dout;
  logic       dout_vld, busy, ovf, frm_err;
  logic       sin_b, sin_vld_b, sof_b, dout_rdy_b, clr_err_b;
  logic [3:0] dout_b;
  logic       dout_vld_b, busy_b, ovf_b, frm_err_b;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_w;
  logic [3:0] tmp_w;

  serial2parallel #(.WIDTH(4), .LSB_FIRST(1), .CONT(1)) dut (
    .clk(clk), .rst_(rst_), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .busy(busy),
    .ovf(ovf), .frm_err(frm_err), .clr_err(clr_err)
  );

  serial2parallel #(.WIDTH(4), .LSB_FIRST(0), .CONT(0)) dut_b (
    .clk(clk), .rst_(rst_), .sin(sin_b), .sin_vld(sin_vld_b), .sof(sof_b),
    .dout(dout_b), .dout_vld(dout_vld_b), .dout_rdy(dout_rdy_b), .busy(busy_b),
    .ovf(ovf_b), .frm_err(frm_err_b), .clr_err(clr_err_b)
  );

  task automatic bit_a(input logic s, input logic b);
    @(negedge clk);
    sof = s; sin = b; sin_vld = 1'b1;
  endtask

  task automatic idle_a();
    @(negedge clk);
    sof = 1'b0; sin = 1'b0; sin_vld = 1'b0;
  endtask

  task automatic bit_b(input logic s, input logic b);
    @(negedge clk);
    sof_b = s; sin_b = b; sin_vld_b = 1'b1;
  endtask

  task automatic idle_b();
    @(negedge clk);
    sof_b = 1'b0; sin_b = 1'b0; sin_vld_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    sin = 1'b0; sin_vld = 1'b0; sof = 1'b0; dout_rdy = 1'b0; clr_err = 1'b0;
    sin_b = 1'b0; sin_vld_b = 1'b0; sof_b = 1'b0; dout_rdy_b = 1'b0; clr_err_b = 1'b0;
    #2;
    tests++;
    if ({dout, dout_vld, busy, ovf, frm_err} !== 8'h00) begin
      fails++;
      $display("FAIL reset_a: got dout=%b vld=%b busy=%b ovf=%b frm=%b, want all 0",
               dout, dout_vld, busy, ovf, frm_err);
    end
    tests++;
    if ({dout_b, dout_vld_b, busy_b, ovf_b, frm_err_b} !== 8'h00) begin
      fails++;
      $display("FAIL reset_b: got dout=%b vld=%b busy=%b, want all 0", dout_b, dout_vld_b, busy_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_basic();
    dout_rdy = 1'b1;
    exp_q.push_back(4'b1011);
    bit_a(1'b1, 1'b1); bit_a(1'b0, 1'b1); bit_a(1'b0, 1'b0); bit_a(1'b0, 1'b1);
    idle_a();
    tests++;
    if (dout_vld !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL basic_vld: got dout_vld=%b, want 1", dout_vld);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout !== exp_w) begin
        fails++;
        $display("FAIL basic_dout: got %b, want %b", dout, exp_w);
      end
    end
    idle_a();
    tests++;
    if (dout_vld !== 1'b0) begin
      fails++;
      $display("FAIL basic_vld_drop: got dout_vld=%b, want 0", dout_vld);
    end
  endtask

  task automatic test_gaps();
    tmp_w = 4'b1011;
    exp_q.push_back(tmp_w);
    for (int k = 0; k < 4; k++) begin
      bit_a(k == 0, tmp_w[k]);
      if (k < 3) begin
        idle_a(); idle_a();
        tests++;
        if (busy !== 1'b1 || dout_vld !== 1'b0) begin
          fails++;
          $display("FAIL gaps_busy[%0d]: got busy=%b vld=%b, want busy=1 vld=0", k, busy, dout_vld);
        end
      end
    end
    idle_a();
    tests++;
    if (dout_vld !== 1'b1 || busy !== 1'b0 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL gaps_done: got vld=%b busy=%b, want vld=1 busy=0", dout_vld, busy);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout !== exp_w) begin
        fails++;
        $display("FAIL gaps_dout: got %b, want %b", dout, exp_w);
      end
    end
    idle_a();
  endtask

  task automatic test_back_to_back();
    dout_rdy = 1'b0;
    exp_q.push_back(4'hA);
    for (int k = 0; k < 8; k++) begin
      tmp_w = (k < 4) ? 4'hA : 4'h5;
      bit_a(k == 0, tmp_w[k % 4]);
    end
    idle_a(); idle_a();
    tests++;
    if (dout_vld !== 1'b1 || ovf !== 1'b1 || dout !== 4'hA) begin
      fails++;
      $display("FAIL b2b_hold: got dout=%h vld=%b ovf=%b, want dout=a vld=1 ovf=1", dout, dout_vld, ovf);
    end
    dout_rdy = 1'b1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL b2b_accept: scoreboard empty, dout=%h", dout);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout !== exp_w) begin
        fails++;
        $display("FAIL b2b_accept: got %h, want %h", dout, exp_w);
      end
    end
    idle_a(); idle_a();
    tests++;
    if (dout_vld !== 1'b0) begin
      fails++;
      $display("FAIL b2b_dropped: got vld=%b dout=%h, want vld=0", dout_vld, dout);
    end
    clr_err = 1'b1;
    idle_a();
    clr_err = 1'b0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL b2b_clr_ovf: got ovf=%b, want 0", ovf);
    end
  endtask

  task automatic test_framing();
    dout_rdy = 1'b1;
    exp_q.push_back(4'b1100);
    bit_a(1'b1, 1'b1); bit_a(1'b0, 1'b0);
    bit_a(1'b1, 1'b0); bit_a(1'b0, 1'b0); bit_a(1'b0, 1'b1); bit_a(1'b0, 1'b1);
    idle_a();
    tests++;
    if (frm_err !== 1'b1 || dout_vld !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL frm_set: got frm_err=%b vld=%b, want 1 1", frm_err, dout_vld);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout !== exp_w) begin
        fails++;
        $display("FAIL frm_dout: got %b, want %b", dout, exp_w);
      end
    end
    clr_err = 1'b1;
    idle_a();
    clr_err = 1'b0;
    tests++;
    if (frm_err !== 1'b0) begin
      fails++;
      $display("FAIL frm_clr: got frm_err=%b, want 0", frm_err);
    end
    exp_q.push_back(4'b1110);
    bit_a(1'b1, 1'b0);
    bit_a(1'b1, 1'b0);
    clr_err = 1'b1;
    bit_a(1'b0, 1'b1);
    clr_err = 1'b0;
    bit_a(1'b0, 1'b1);
    bit_a(1'b0, 1'b1);
    idle_a();
    tests++;
    if (frm_err !== 1'b1 || dout_vld !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL frm_priority: got frm_err=%b vld=%b, want 1 1", frm_err, dout_vld);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout !== exp_w) begin
        fails++;
        $display("FAIL frm_priority_dout: got %b, want %b", dout, exp_w);
      end
    end
    clr_err = 1'b1;
    idle_a();
    clr_err = 1'b0;
  endtask

  task automatic test_msb_nocont();
    dout_rdy_b = 1'b1;
    exp_q.push_back(4'b1000);
    bit_b(1'b1, 1'b1); bit_b(1'b0, 1'b0); bit_b(1'b0, 1'b0); bit_b(1'b0, 1'b0);
    idle_b();
    tests++;
    if (dout_vld_b !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL msb_vld: got vld=%b, want 1", dout_vld_b);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout_b !== exp_w) begin
        fails++;
        $display("FAIL msb_dout: got %b, want %b", dout_b, exp_w);
      end
    end
    for (int k = 0; k < 4; k++) begin
      bit_b(1'b0, 1'b1);
      idle_b();
      tests++;
      if (busy_b !== 1'b0 || dout_vld_b !== 1'b0) begin
        fails++;
        $display("FAIL nocont_ignore[%0d]: got busy=%b vld=%b, want 0 0", k, busy_b, dout_vld_b);
      end
    end
  endtask

  task automatic test_reset_midword();
    dout_rdy = 1'b0;
    bit_a(1'b1, 1'b1); bit_a(1'b0, 1'b1); bit_a(1'b0, 1'b0); bit_a(1'b0, 1'b0);
    bit_a(1'b1, 1'b1); bit_a(1'b0, 1'b0);
    idle_a();
    tests++;
    if (busy !== 1'b1 || dout_vld !== 1'b1 || dout !== 4'b0011) begin
      fails++;
      $display("FAIL rst_pre: got busy=%b vld=%b dout=%b, want 1 1 0011", busy, dout_vld, dout);
    end
    #2 rst_ = 1'b0;
    #1;
    tests++;
    if ({dout, dout_vld, busy, ovf, frm_err} !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid: got dout=%b vld=%b busy=%b ovf=%b frm=%b, want all 0",
               dout, dout_vld, busy, ovf, frm_err);
    end
    @(negedge clk);
    rst_ = 1'b1;
    dout_rdy = 1'b1;
    exp_q.push_back(4'b0110);
    bit_a(1'b1, 1'b0); bit_a(1'b0, 1'b1); bit_a(1'b0, 1'b1); bit_a(1'b0, 1'b0);
    idle_a();
    tests++;
    if (dout_vld !== 1'b1 || ovf !== 1'b0 || frm_err !== 1'b0 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL rst_after: got vld=%b ovf=%b frm=%b, want 1 0 0", dout_vld, ovf, frm_err);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout !== exp_w) begin
        fails++;
        $display("FAIL rst_after_dout: got %b, want %b", dout, exp_w);
      end
    end
    idle_a();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_framing();
    test_msb_nocont();
    test_reset_midword();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words never produced, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
